instruction_fetch_controller: RTL and testbench



---
 rtl/instruction_fetch_controller.sv | 99 +++++++++
 tb/tb_instruction_fetch_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetch PC sequencer with prefetch queue and redirect flush
// Feeds decode a {instruction, PC, PC+4} stream from a combinational-read instruction memory.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FetchEnable,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic [31:0] DeliveredCount
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      delivered_q, delivered_d;
  logic [31:0]      instr_q [QUEUE_DEPTH];
  logic [31:0]      instr_d [QUEUE_DEPTH];
  logic [31:0]      pc_q    [QUEUE_DEPTH];
  logic [31:0]      pc_d    [QUEUE_DEPTH];
  logic             push;
  logic             pop;

  always_comb begin
    pop  = (count_q != '0) & OutReady & ~Redirect;
    // A full queue still accepts a word when the head leaves in the same cycle.
    push = FetchEnable & ~Redirect & ((count_q < DEPTH_C) | pop);

    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    delivered_d = delivered_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    if (push) begin
      instr_d[wr_ptr_q] = IMemInstruction;
      pc_d[wr_ptr_q]    = fetch_pc_q;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      fetch_pc_d        = fetch_pc_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      delivered_d = delivered_q + 32'd1;
    end

    if (Redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = RedirectTarget & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc_q  <= RESET_PC & 32'hFFFF_FFFC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      delivered_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      delivered_q <= delivered_d;
    end
  end

  // Queue storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge Clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign IMemAddress    = fetch_pc_q;
  assign OutValid       = (count_q != '0);
  assign OutInstruction = instr_q[rd_ptr_q];
  assign OutPC          = pc_q[rd_ptr_q];
  assign OutPCPlus4     = pc_q[rd_ptr_q] + 32'd4;
  assign DeliveredCount = delivered_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - scoreboard bench for instruction_fetch_controller
// Memory model returns (addr>>2)*3; expected pop PCs are queued per scenario.
module tb_instruction_fetch_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        FetchEnable;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic [31:0] DeliveredCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_instr;
  logic [31:0] mon_plus4;

  always #5 Clk = ~Clk;

  assign IMemInstruction = (IMemAddress >> 2) * 32'd3;

  instruction_fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(4)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .FetchEnable    (FetchEnable),
    .IMemAddress    (IMemAddress),
    .IMemInstruction(IMemInstruction),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .OutPCPlus4     (OutPCPlus4),
    .DeliveredCount (DeliveredCount)
  );

  // Inputs change 1 time unit after posedge, so the negedge view is what the next edge sees.
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady && !Redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got OutPC=%h, required no pop", OutPC);
      end else begin
        mon_pc    = exp_q.pop_front();
        mon_instr = (mon_pc >> 2) * 32'd3;
        mon_plus4 = mon_pc + 32'd4;
        if (OutPC !== mon_pc || OutInstruction !== mon_instr || OutPCPlus4 !== mon_plus4) begin
          errors++;
          $display("FAIL pop_data: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   OutPC, OutInstruction, OutPCPlus4, mon_pc, mon_instr, mon_plus4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle after reset release).
  task automatic do_reset(input logic fe, input logic rdy);
    exp_q.delete();
    Reset = 1'b1;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    FetchEnable = fe;
    OutReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    OutReady = rdy;
  endtask

  task automatic check_drained(input string name, input logic [31:0] exp_delivered);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d outstanding, required 0", name, exp_q.size());
    end
    checks++;
    if (DeliveredCount !== exp_delivered) begin
      errors++;
      $display("FAIL %s_delivered: got %0d, required %0d", name, DeliveredCount, exp_delivered);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if (IMemAddress !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h, required %h", IMemAddress, 32'h0);
    end
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", OutValid);
    end
    checks++;
    if (DeliveredCount !== 32'h0) begin
      errors++;
      $display("FAIL reset_delivered: got %0d, required 0", DeliveredCount);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutPC !== 32'h0) begin
      errors++;
      $display("FAIL stream_first: got valid=%b pc=%h, required valid=1 pc=0", OutValid, OutPC);
    end
    repeat (5) tick();
    OutReady = 1'b0;
    check_drained("stream", 32'd5);
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    repeat (8) tick();
    checks++;
    if (IMemAddress !== 32'h10) begin
      errors++;
      $display("FAIL bp_stall_addr: got %h, required %h", IMemAddress, 32'h10);
    end
    checks++;
    if (OutValid !== 1'b1 || OutPC !== 32'h0) begin
      errors++;
      $display("FAIL bp_head: got valid=%b pc=%h, required valid=1 pc=0", OutValid, OutPC);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    OutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (OutValid !== 1'b1) begin
        errors++;
        $display("FAIL bp_gap: cycle %0d got valid=%b, required 1", i, OutValid);
      end
      tick();
    end
    OutReady = 1'b0;
    check_drained("bp", 32'd5);
  endtask

  task automatic test_redirect();
    do_reset(1'b1, 1'b0);
    repeat (3) tick();
    Redirect = 1'b1;
    RedirectTarget = 32'h0000_0103;
    OutReady = 1'b1;
    tick();
    Redirect = 1'b0;
    exp_q.push_back(32'h100);
    checks++;
    if (IMemAddress !== 32'h100 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_next: got addr=%h valid=%b, required addr=100 valid=0", IMemAddress, OutValid);
    end
    checks++;
    if (DeliveredCount !== 32'h0) begin
      errors++;
      $display("FAIL redir_no_pop: got %0d, required 0", DeliveredCount);
    end
    tick();
    checks++;
    if (OutValid !== 1'b1 || OutPC !== 32'h100 || OutInstruction !== 32'hC0) begin
      errors++;
      $display("FAIL redir_head: got valid=%b pc=%h instr=%h, required valid=1 pc=100 instr=c0",
               OutValid, OutPC, OutInstruction);
    end
    tick();
    OutReady = 1'b0;
    check_drained("redir", 32'd1);
  endtask

  task automatic test_fetch_enable();
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    repeat (3) tick();
    FetchEnable = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (OutValid !== 1'b0 || IMemAddress !== 32'hC) begin
        errors++;
        $display("FAIL fe_hold: cycle %0d got valid=%b addr=%h, required valid=0 addr=c",
                 i, OutValid, IMemAddress);
      end
      tick();
    end
    FetchEnable = 1'b1;
    checks++;
    if (IMemAddress !== 32'hC) begin
      errors++;
      $display("FAIL fe_resume: got addr=%h, required c", IMemAddress);
    end
    repeat (3) tick();
    OutReady = 1'b0;
    check_drained("fe", 32'd5);
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b1);
    Redirect = 1'b1;
    RedirectTarget = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick();
    Redirect = 1'b0;
    tick();
    tick();
    checks++;
    if (OutPC !== 32'hFFFF_FFFC || OutPCPlus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: got pc=%h pc4=%h, required pc=fffffffc pc4=0", OutPC, OutPCPlus4);
    end
    tick();
    tick();
    OutReady = 1'b0;
    check_drained("wrap", 32'd3);
  endtask

  task automatic test_reset_redirect();
    do_reset(1'b1, 1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    repeat (3) tick();
    OutReady = 1'b0;
    repeat (3) tick();
    check_drained("rr_pre", 32'd2);
    checks++;
    if (IMemAddress !== 32'h18) begin
      errors++;
      $display("FAIL rr_full: got addr=%h, required 18", IMemAddress);
    end
    Reset = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 32'h200;
    OutReady = 1'b1;
    tick();
    Reset = 1'b0;
    Redirect = 1'b0;
    FetchEnable = 1'b0;
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0 || IMemAddress !== 32'h0 || DeliveredCount !== 32'h0) begin
      errors++;
      $display("FAIL rr_result: got valid=%b addr=%h dc=%0d, required valid=0 addr=0 dc=0",
               OutValid, IMemAddress, DeliveredCount);
    end
  endtask

  initial begin
    Reset = 1'b1;
    FetchEnable = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = 32'h0;
    OutReady = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fetch_enable();
    test_wrap();
    test_reset_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
